instr_sequencer: RTL and testbench

- Control stage directly upstream of the 2-bit program counter.
- Holds a 4-entry loadable instruction store and consumes the PC address (p1,p0).
- Runs a FETCH/EXEC state machine that drives the counter's jnp, inc, i1, i0 and r2 inputs.
- Owns the accumulator register, whose sticky overflow bit is r2.

---
 rtl/instr_sequencer_pkg.sv | 32 +++
 rtl/instr_sequencer_store.sv | 29 ++
 rtl/instr_sequencer.sv | 116 +++++++++++
 tb/tb_instr_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// instruction word layout.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_JNP  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam int INSTR_W     = 4;
    localparam int STORE_DEPTH = 4;
    localparam int OPC_HI      = 3;
    localparam int OPC_LO      = 2;
    localparam int OPD_HI      = 1;
    localparam int OPD_LO      = 0;

    function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [1:0] operand_of(input logic [INSTR_W-1:0] word);
        return word[OPD_HI:OPD_LO];
    endfunction

endpackage

// File: rtl/instr_sequencer_store.sv
// Four-word instruction store: flop array cleared to HALT on reset,
// one write port and a combinational read port addressed by the PC.
module instr_store
    import instr_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [1:0]         rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [STORE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STORE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// FETCH/EXEC sequencer driving the 2-bit program counter; owns the
// accumulator, its sticky overflow flag r2 and the retired-instruction count.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int REG_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [3:0]       wr_data,
    input  logic             p1,
    input  logic             p0,
    output logic             jnp,
    output logic             inc,
    output logic             i1,
    output logic             i0,
    output logic             r2,
    output logic [REG_W-1:0] acc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t             state;
    logic [1:0]         ir_op;
    logic [INSTR_W-1:0] fetch_word;
    logic               store_we;

    // The store is only writable while the sequencer is parked.
    assign store_we = wr_en && (state == ST_IDLE || state == ST_HALTED);

    instr_store u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (store_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr ({p1, p0}),
        .rd_data (fetch_word)
    );

    // Outputs are loaded one edge ahead so they hold for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ir_op   <= OP_HALT;
            jnp     <= 1'b0;
            inc     <= 1'b0;
            i1      <= 1'b0;
            i0      <= 1'b0;
            r2      <= 1'b0;
            acc     <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state  <= ST_FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir_op <= opcode_of(fetch_word);
                    if (opcode_of(fetch_word) == OP_HALT) begin
                        state  <= ST_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                        inc   <= (opcode_of(fetch_word) == OP_INC) ||
                                 (opcode_of(fetch_word) == OP_CLR);
                        jnp   <= (opcode_of(fetch_word) == OP_JNP);
                        if (opcode_of(fetch_word) == OP_JNP) begin
                            {i1, i0} <= operand_of(fetch_word);
                        end else begin
                            {i1, i0} <= 2'b00;
                        end
                    end
                end
                ST_EXEC: begin
                    state    <= ST_FETCH;
                    jnp      <= 1'b0;
                    inc      <= 1'b0;
                    {i1, i0} <= 2'b00;
                    retired  <= retired + CNT_W'(1);
                    case (ir_op)
                        OP_INC: begin
                            if (acc == '1) begin
                                r2 <= 1'b1;
                            end
                            acc <= acc + REG_W'(1);
                        end
                        OP_CLR: begin
                            acc <= '0;
                            r2  <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural PC, instruction-level reference model
// feeding a per-cycle scoreboard, table of programs plus corner sequences.
module tb_instr_sequencer;

    localparam int REG_W = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [3:0]       wr_data;
    logic             p1;
    logic             p0;
    logic             jnp;
    logic             inc;
    logic             i1;
    logic             i0;
    logic             r2;
    logic [REG_W-1:0] acc;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic       busy;
        logic       halted;
        logic       inc;
        logic       jnp;
        logic [1:0] tgt;
        logic [1:0] acc;
        logic       r2;
        logic [7:0] retired;
    } obs_t;

    typedef struct {
        logic [15:0] prog;
        logic [1:0]  pc0;
        logic [1:0]  acc;
        logic        r2;
        logic [7:0]  ret_delta;
        int          busy_cycles;
    } vec_t;

    obs_t       dut_obs;
    obs_t       sb[$];
    vec_t       vecs[5];
    logic [3:0] exp_mem[4];
    logic [1:0] exp_acc;
    logic       exp_r2;
    logic [7:0] exp_retired;
    logic [7:0] hand_retired;
    int         checks;
    int         failures;
    int         n_inc;

    logic [1:0] pc;
    logic       pc_load;
    logic [1:0] pc_load_val;

    instr_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .p1      (p1),
        .p0      (p0),
        .jnp     (jnp),
        .inc     (inc),
        .i1      (i1),
        .i0      (i0),
        .r2      (r2),
        .acc     (acc),
        .busy    (busy),
        .halted  (halted),
        .retired (retired)
    );

    assign dut_obs = {busy, halted, inc, jnp, i1, i0, acc, r2, retired};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter the sequencer drives; jnp falls through by two on overflow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc <= 2'd0;
        else if (pc_load) pc <= pc_load_val;
        else if (jnp)     pc <= r2 ? pc + 2'd2 : {i1, i0};
        else if (inc)     pc <= pc + 2'd1;
    end
    assign p1 = pc[1];
    assign p0 = pc[0];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic loadWord(input logic [1:0] addr, input logic [3:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        exp_mem[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic setPc(input logic [1:0] value);
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = value;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    // Instruction-level model: one FETCH record, then EXEC or HALTED record.
    task automatic predict(input logic [1:0] pc_start);
        logic [1:0] p;
        logic [3:0] w;
        obs_t       r;
        bit         done;
        p    = pc_start;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            w         = exp_mem[p];
            r         = '0;
            r.busy    = 1'b1;
            r.acc     = exp_acc;
            r.r2      = exp_r2;
            r.retired = exp_retired;
            sb.push_back(r);
            if (w[3:2] == 2'b00) begin
                r.busy   = 1'b0;
                r.halted = 1'b1;
                sb.push_back(r);
                done = 1'b1;
            end else begin
                r.inc = (w[3:2] != 2'b10);
                r.jnp = (w[3:2] == 2'b10);
                r.tgt = r.jnp ? w[1:0] : 2'b00;
                sb.push_back(r);
                case (w[3:2])
                    2'b01: begin
                        if (exp_acc == 2'b11) exp_r2 = 1'b1;
                        exp_acc = exp_acc + 2'd1;
                        p = p + 2'd1;
                    end
                    2'b10: p = exp_r2 ? p + 2'd2 : w[1:0];
                    default: begin
                        exp_acc = 2'b00;
                        exp_r2  = 1'b0;
                        p = p + 2'd1;
                    end
                endcase
                exp_retired = exp_retired + 8'd1;
            end
        end
    endtask

    // Pulses start, optionally with a same-cycle write to address 0; inj>0
    // pulses start on that busy sample and writes 1111 to address 0 on the next.
    task automatic applyStimulus(input string name, input bit sim_write,
                                 input logic [3:0] sim_data, input int inj,
                                 input int exp_busy);
        int   idx;
        int   n_busy;
        obs_t e;
        @(negedge clk);
        start = 1'b1;
        if (sim_write) begin
            wr_en      = 1'b1;
            wr_addr    = 2'd0;
            wr_data    = sim_data;
            exp_mem[0] = sim_data;
        end
        predict(pc);
        idx    = 0;
        n_busy = 0;
        while (sb.size() > 0 && idx < 100) begin
            @(negedge clk);
            idx++;
            start = 1'b0;
            wr_en = 1'b0;
            if (inj > 0 && idx == inj) start = 1'b1;
            if (inj > 0 && idx == inj + 1) begin
                wr_en   = 1'b1;
                wr_addr = 2'd0;
                wr_data = 4'b1111;
            end
            e = sb.pop_front();
            checkOutput($sformatf("%s_cyc%0d", name, idx), {15'd0, dut_obs}, {15'd0, e});
            checkOutput($sformatf("%s_excl%0d", name, idx), {31'd0, inc & jnp}, 32'd0);
            if (busy) n_busy++;
        end
        if (sb.size() > 0) begin
            checkOutput({name, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        start = 1'b0;
        wr_en = 1'b0;
        checkOutput({name, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = 2'd0;
        wr_data      = 4'd0;
        pc_load      = 1'b0;
        pc_load_val  = 2'd0;
        exp_acc      = 2'd0;
        exp_r2       = 1'b0;
        exp_retired  = 8'd0;
        hand_retired = 8'd0;
        for (int i = 0; i < 4; i++) exp_mem[i] = 4'd0;

        // prog = {word0, word1, word2, word3}; state carries over between rows
        vecs[0] = '{16'h4800, 2'd0, 2'd0, 1'b1, 8'd8, 17};
        vecs[1] = '{16'hC400, 2'd0, 2'd1, 1'b0, 8'd2, 5};
        vecs[2] = '{16'hB004, 2'd0, 2'd0, 1'b1, 8'd7, 15};
        vecs[3] = '{16'h0000, 2'd0, 2'd0, 1'b1, 8'd0, 1};
        vecs[4] = '{16'hCA04, 2'd0, 2'd0, 1'b0, 8'd2, 5};

        repeat (2) @(negedge clk);
        checkOutput("reset_state", {15'd0, dut_obs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_state", {15'd0, dut_obs}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) loadWord(2'(j), vecs[i].prog[15-4*j -: 4]);
            setPc(vecs[i].pc0);
            applyStimulus($sformatf("vec%0d", i), 1'b0, 4'd0, 0, vecs[i].busy_cycles);
            hand_retired = hand_retired + vecs[i].ret_delta;
            checkOutput($sformatf("vec%0d_acc", i), {30'd0, acc}, {30'd0, vecs[i].acc});
            checkOutput($sformatf("vec%0d_r2", i), {31'd0, r2}, {31'd0, vecs[i].r2});
            checkOutput($sformatf("vec%0d_retired", i), {24'd0, retired}, {24'd0, hand_retired});
            checkOutput($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd1);
        end

        // Write and start in the same parked cycle: INC must run, not HALT.
        setPc(2'd0);
        applyStimulus("wr_start_same", 1'b1, 4'b0100, 0, 5);
        checkOutput("wr_start_same_acc", {30'd0, acc}, 32'd1);

        // start in FETCH and a write in EXEC must both be ignored.
        loadWord(2'd0, 4'b0000);
        loadWord(2'd1, 4'b0100);
        loadWord(2'd2, 4'b0000);
        loadWord(2'd3, 4'b0000);
        setPc(2'd1);
        applyStimulus("ignored_inputs", 1'b0, 4'd0, 1, 3);
        setPc(2'd0);
        applyStimulus("refetch_addr0", 1'b0, 4'd0, 0, 1);
        checkOutput("refetch_acc", {30'd0, acc}, 32'd2);

        // Asynchronous reset in the middle of an INC execute cycle.
        loadWord(2'd0, 4'b0100);
        loadWord(2'd1, 4'b1000);
        setPc(2'd0);
        @(negedge clk);
        start = 1'b1;
        n_inc = 0;
        for (int k = 0; k < 40 && n_inc < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inc) n_inc++;
        end
        start = 1'b0;
        checkOutput("mid_exec_reached", 32'(n_inc), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_exec", {15'd0, dut_obs}, 32'd0);
        for (int i = 0; i < 4; i++) exp_mem[i] = 4'd0;
        exp_acc     = 2'd0;
        exp_r2      = 1'b0;
        exp_retired = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_reset_fetch", 1'b0, 4'd0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
